// File: rtl/mips_irq_pkg.sv
// Shared encodings and defaults for the MIPS single-level interrupt sequencer.
package mips_irq_pkg;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_ISR  = 1'b1
    } irq_state_e;

    localparam logic [5:0]  OP_RES                = 6'b11_1111;
    localparam logic [31:0] DEFAULT_VECTOR_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEFAULT_VECTOR_STRIDE = 32'h0000_0010;

    // Index width for a line count; a single line still needs one bit.
    function automatic int irq_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Vector address wraps modulo 2^32 by construction of the 32-bit result.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] idx);
        logic [31:0] off;
        off = stride * idx;
        return base + off;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: index, valid flag and one-hot grant.
module irq_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] sel,
    output logic            valid,
    output logic [N-1:0]    onehot
);

    // Scan from the top down so the lowest set index is the last to assign.
    always_comb begin
        sel    = '0;
        valid  = 1'b0;
        onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel       = ID_W'(i);
                valid     = 1'b1;
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Single-level interrupt sequencer: edge capture, priority take, PC redirect and EPC restore.
module irq_sequencer
    import mips_irq_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [31:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
    parameter logic [31:0] VECTOR_STRIDE = DEFAULT_VECTOR_STRIDE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IRQ-1:0]            irq_in,
    input  logic [NUM_IRQ-1:0]            irq_mask,
    input  logic                          cpu_en,
    input  logic [31:0]                   pc_next_in,
    input  logic                          irq_resume,
    output logic                          pc_override,
    output logic [31:0]                   pc_override_addr,
    output logic                          in_isr,
    output logic [NUM_IRQ-1:0]            irq_ack,
    output logic [irq_id_w(NUM_IRQ)-1:0]  irq_id,
    output logic [NUM_IRQ-1:0]            pending,
    output logic                          err_spurious
);

    localparam int ID_W = irq_id_w(NUM_IRQ);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q, pending_q;
    logic [NUM_IRQ-1:0] edges, req, sel_onehot;
    logic [ID_W-1:0]    sel, irq_id_q;
    logic               sel_vld;
    logic [31:0]        epc_q;
    logic               take, resume, spurious;

    assign edges = irq_in & ~irq_prev_q;
    assign req   = pending_q & irq_mask;

    irq_prio_enc #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio (
        .req    (req),
        .sel    (sel),
        .valid  (sel_vld),
        .onehot (sel_onehot)
    );

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        resume   = 1'b0;
        spurious = 1'b0;
        if (!rst && cpu_en) begin
            case (state_q)
                IRQ_IDLE: begin
                    spurious = irq_resume;
                    if (sel_vld) begin
                        take    = 1'b1;
                        state_d = IRQ_ISR;
                    end
                end
                IRQ_ISR: begin
                    if (irq_resume) begin
                        resume  = 1'b1;
                        state_d = IRQ_IDLE;
                    end
                end
                default: state_d = IRQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IRQ_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            epc_q      <= '0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_in;
            // A fresh edge on the line being taken re-arms it.
            pending_q  <= (pending_q & ~(take ? sel_onehot : '0)) | edges;
            if (take) begin
                epc_q    <= pc_next_in;
                irq_id_q <= sel;
            end
        end
    end

    // Registered views are masked during reset so every output reads 0 immediately.
    always_comb begin
        pc_override      = take | resume;
        pc_override_addr = '0;
        if (take)
            pc_override_addr = vec_addr(VECTOR_BASE, VECTOR_STRIDE, 32'(sel));
        else if (resume)
            pc_override_addr = epc_q;
        irq_ack      = take ? sel_onehot : '0;
        err_spurious = spurious;
        in_isr       = !rst && (state_q == IRQ_ISR);
        irq_id       = rst ? '0 : irq_id_q;
        pending      = rst ? '0 : pending_q;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Single-level interrupt sequencer for the single-cycle MIPS core.
- Captures external interrupt edges, selects the highest-priority unmasked request, and redirects the PC to a per-line vector while saving the return PC (EPC).
- On the RES instruction (decoder output irq_resume), restores the saved PC.
- Sits between the main decoder / PC-next logic and the SoC interrupt sources; its PC override feeds the final PC-next mux.

Parameters:
- NUM_IRQ, 4: number of interrupt lines (1..8).
- VECTOR_BASE, 32'h0000_0100: ISR address for line 0.
- VECTOR_STRIDE, 32'h0000_0010: byte spacing between consecutive line vectors.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw interrupt lines, synchronous to clk; rising edge requests service.
- irq_mask  in  NUM_IRQ  1 = line enabled.
- cpu_en  in  1  core advancing this cycle; no take or resume when 0.
- pc_next_in  in  32  PC the core would load at the next edge.
- irq_resume  in  1  from main decoder; RES instruction executing.
- pc_override  out  1  1 = PC loads pc_override_addr at the next edge.
- pc_override_addr  out  32  vector address or EPC.
- in_isr  out  1  core is executing an ISR.
- irq_ack  out  NUM_IRQ  one-hot, 1-cycle pulse on take.
- irq_id  out  clog2(NUM_IRQ) (min 1)  line being serviced; valid while in_isr.
- pending  out  NUM_IRQ  current pending register.
- err_spurious  out  1  1-cycle pulse when RES executes outside an ISR.

Behaviour:
- Edge capture:
  - irq_prev register; edge[i] = irq_in[i] & ~irq_prev[i].
  - pending[i] is set on edge, cleared on take of line i.
  - Set wins over clear in the same cycle.
  - Masked lines still pend and are never selected while masked.
- Selection: req = pending & irq_mask; the lowest set index wins (line 0 highest priority).
- State machine, states IDLE and ISR:
  - IDLE -> ISR when req != 0 and cpu_en = 1 (the "take" cycle). Take-cycle actions, combinational from registered state and pending:
    - pc_override = 1; pc_override_addr = VECTOR_BASE + sel*VECTOR_STRIDE, 32-bit modulo.
    - irq_ack[sel] = 1.
    - Registered at the edge: epc <= pc_next_in, irq_id <= sel, pending[sel] cleared.
  - ISR -> IDLE when irq_resume = 1 and cpu_en = 1. That cycle: pc_override = 1, pc_override_addr = epc.
  - ISR with irq_resume = 0: hold. New edges pend; no nesting.
  - IDLE with irq_resume = 1 and cpu_en = 1: pc_override = 0, err_spurious = 1 for that cycle, no state change.
- in_isr = (state == ISR), registered, so it is 1 from the cycle after take.
- Earliest re-take is the cycle after the resume cycle; never in the resume cycle itself.
- cpu_en = 0: no transitions, pc_override = 0, irq_ack = 0. Edge capture continues.
- Latency: edge at cycle N -> pending at N+1 -> take (pc_override) at N+1 if IDLE, unmasked and cpu_en -> PC = vector at N+2.
- Reset (synchronous, active-high):
  - state = IDLE; pending = 0; irq_prev = 0; epc = 0; irq_id = 0.
  - All outputs 0.
  - Reset mid-ISR abandons the ISR; no resume is generated.
- pc_override_addr = 0 whenever pc_override = 0.

Decomposition:
- Package mips_irq_pkg holds: state encoding (IRQ_IDLE = 1'b0, IRQ_ISR = 1'b1), OP_RES = 6'b11_1111, default VECTOR_BASE and VECTOR_STRIDE.
- One sub-module, irq_prio_enc: parameterized lowest-index priority encoder.
  - Input: req.
  - Outputs: sel index and valid.
  - Also produces the one-hot irq_ack.

Test Plan:
- Reset then pulse irq_in[2], mask = 4'b1111, pc_next_in = 32'h40 -> next cycle: pc_override = 1, addr = 32'h120, irq_ack = 4'b0100; then in_isr = 1, irq_id = 2.
- In ISR, assert irq_resume with pc_next_in = 32'h128 -> pc_override = 1, addr = 32'h40; next cycle in_isr = 0.
- Edges on lines 1 and 3 in the same cycle -> line 1 taken (addr 32'h110); after resume, line 3 taken on the following cycle (addr 32'h130).
- Edge on line 0 with mask[0] = 0 -> pending = 4'b0001, no override; set mask[0] = 1 -> take next cycle, addr 32'h100.
- irq_resume while IDLE -> err_spurious pulse, pc_override = 0; edge on line 1 while in ISR -> stays pending, no nested take.
- Reset asserted mid-ISR with line 2 pending -> all outputs and pending = 0; cpu_en = 0 with a pending line -> no take until cpu_en returns to 1.
